// File: rtl/tetris_vga_pkg.sv
// Shared colour types, palette and helpers for the Tetris board renderer.
package tetris_vga_pkg;

  localparam int unsigned RGB_W  = 12;
  localparam int unsigned CIDX_W = 3;
  localparam int unsigned PAL_N  = 8;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t BLACK      = 12'h000;
  localparam rgb_t GREY       = 12'h333;
  localparam rgb_t LIGHT_GREY = 12'hAAA;

  // Entry 0 is deliberately visible so an occupied cell with index 0 still shows.
  localparam rgb_t PALETTE [0:PAL_N-1] = '{
    LIGHT_GREY, 12'h0FF, 12'h00F, 12'hF80,
    12'hFF0,    12'hF0F, 12'h0F0, 12'hF00
  };

  // Halve every channel for the bevel edge.
  function automatic rgb_t dim(input rgb_t c);
    rgb_t d;
    d.r = {1'b0, c.r[3:1]};
    d.g = {1'b0, c.g[3:1]};
    d.b = {1'b0, c.b[3:1]};
    return d;
  endfunction

endpackage

// File: rtl/cell_locator.sv
// Stage 1: tracks in-cell pixel offsets and cell indices with counters and flags board/frame windows.
module cell_locator
  import tetris_vga_pkg::*;
#(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 20,
  parameter int unsigned CELL = 20,
  parameter int unsigned X0   = 220,
  parameter int unsigned Y0   = 40,
  localparam int unsigned XI_W  = $clog2(CELL),
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             pix_en,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  input  logic             bright,
  output logic [XI_W-1:0]  xi,
  output logic [XI_W-1:0]  yi,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             in_board,
  output logic             in_frame,
  output logic             bright_q
);

  localparam logic [9:0] BX0 = 10'(X0);
  localparam logic [9:0] BX1 = 10'(X0 + COLS * CELL - 1);
  localparam logic [9:0] BY0 = 10'(Y0);
  localparam logic [9:0] BY1 = 10'(Y0 + ROWS * CELL - 1);
  localparam logic [9:0] FX0 = 10'(X0 - 1);
  localparam logic [9:0] FX1 = 10'(X0 + COLS * CELL);
  localparam logic [9:0] FY0 = 10'(Y0 - 1);
  localparam logic [9:0] FY1 = 10'(Y0 + ROWS * CELL);

  localparam logic [XI_W-1:0]  XI_LAST  = XI_W'(CELL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic board_c;
  logic frame_c;

  always_comb begin
    board_c = (hCount >= BX0) && (hCount <= BX1) && (vCount >= BY0) && (vCount <= BY1);
    frame_c = (hCount >= FX0) && (hCount <= FX1) && (vCount >= FY0) && (vCount <= FY1);
  end

  // Indices saturate outside the board; in_board masks whatever they hold there.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      xi       <= '0;
      yi       <= '0;
      col      <= '0;
      row      <= '0;
      in_board <= 1'b0;
      in_frame <= 1'b0;
      bright_q <= 1'b0;
    end else if (pix_en) begin
      if (hCount == BX0) begin
        xi  <= '0;
        col <= '0;
      end else if (xi == XI_LAST) begin
        xi <= '0;
        if (col != COL_LAST) col <= col + 1'b1;
      end else begin
        xi <= xi + 1'b1;
      end

      if (hCount == 10'd0) begin
        if (vCount == BY0) begin
          yi  <= '0;
          row <= '0;
        end else if (yi == XI_LAST) begin
          yi <= '0;
          if (row != ROW_LAST) row <= row + 1'b1;
        end else begin
          yi <= yi + 1'b1;
        end
      end

      in_board <= board_c;
      in_frame <= frame_c;
      bright_q <= bright;
    end
  end

endmodule

// File: rtl/tetris_board_renderer.sv
// Pipelined board painter: frame snapshot of the board, cell locator, and palette/bevel/flash colour mux.
module tetris_board_renderer
  import tetris_vga_pkg::*;
#(
  parameter int unsigned COLS      = 10,
  parameter int unsigned ROWS      = 20,
  parameter int unsigned CELL      = 20,
  parameter int unsigned X0        = 220,
  parameter int unsigned Y0        = 40,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned FLASH_BIT = 3
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          pix_en,
  input  logic [9:0]                    hCount,
  input  logic [9:0]                    vCount,
  input  logic                          bright,
  input  logic [ROWS*COLS-1:0]          board_occ,
  input  logic [CIDX_W*ROWS*COLS-1:0]   board_color,
  input  logic [ROWS-1:0]               flash_rows,
  input  logic                          border_en,
  output logic [RGB_W-1:0]              rgb,
  output logic                          frame_tick
);

  localparam int unsigned XI_W  = $clog2(CELL);
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [9:0]  SNAP_V = 10'(V_ACTIVE);

  if ((X0 + COLS * CELL + 1 > 639) || (Y0 + ROWS * CELL + 1 > V_ACTIVE - 1)) begin : g_bad_geom
    $error("tetris_board_renderer: board plus frame does not fit the active area");
  end
  if ((X0 == 0) || (Y0 == 0)) begin : g_bad_origin
    $error("tetris_board_renderer: X0 and Y0 must leave room for the 1-px frame");
  end
  if (CELL < 4) begin : g_bad_cell
    $error("tetris_board_renderer: CELL must be at least 4");
  end
  if (FLASH_BIT >= CNT_W) begin : g_bad_flash
    $error("tetris_board_renderer: FLASH_BIT exceeds frame counter width");
  end

  logic                    occ_sh [ROWS][COLS];
  logic [CIDX_W-1:0]       cidx_sh [ROWS][COLS];
  logic [ROWS-1:0]         flash_sh;
  logic [CNT_W-1:0]        frame_cnt;

  logic [XI_W-1:0]  xi;
  logic [XI_W-1:0]  yi;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             in_board;
  logic             in_frame;
  logic             bright_q;

  logic snap_c;
  assign snap_c = pix_en && (vCount == SNAP_V) && (hCount == 10'd0);

  cell_locator #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CELL (CELL),
    .X0   (X0),
    .Y0   (Y0)
  ) u_loc (
    .Clk      (Clk),
    .Reset    (Reset),
    .pix_en   (pix_en),
    .hCount   (hCount),
    .vCount   (vCount),
    .bright   (bright),
    .xi       (xi),
    .yi       (yi),
    .col      (col),
    .row      (row),
    .in_board (in_board),
    .in_frame (in_frame),
    .bright_q (bright_q)
  );

  // Only this copy is drawn, so the picture never tears when game logic updates mid-frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          occ_sh[r][c]  <= 1'b0;
          cidx_sh[r][c] <= '0;
        end
      end
      flash_sh   <= '0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap_c;
      if (snap_c) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            occ_sh[r][c]  <= board_occ[r*COLS + c];
            cidx_sh[r][c] <= board_color[CIDX_W*(r*COLS + c) +: CIDX_W];
          end
        end
        flash_sh  <= flash_rows;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  rgb_t pix_c;
  rgb_t cell_c;
  logic show_c;

  // Stage-2 colour selection in priority order.
  always_comb begin
    pix_c  = BLACK;
    cell_c = PALETTE[cidx_sh[row][col]];
    show_c = in_board && occ_sh[row][col] && !(flash_sh[row] && frame_cnt[FLASH_BIT]);
    if (border_en && ((xi == '0) || (yi == '0))) cell_c = dim(cell_c);
    if (!bright_q)     pix_c = BLACK;
    else if (show_c)   pix_c = cell_c;
    else if (in_frame) pix_c = GREY;
    else               pix_c = BLACK;
  end

  always_ff @(posedge Clk) begin
    if (Reset)       rgb <= '0;
    else if (pix_en) rgb <= pix_c;
  end

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Directed bench for tetris_board_renderer with hand-computed expected pixels.
module tb_tetris_board_renderer;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CELL = 20;
  localparam int X0   = 220;
  localparam int Y0   = 40;
  localparam int VA   = 480;

  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_GREY  = 12'h333;
  localparam logic [11:0] C_LG    = 12'hAAA;
  localparam logic [11:0] C_PAL3  = 12'hF80;
  localparam logic [11:0] C_DIM3  = 12'h740;
  localparam logic [11:0] C_PAL5  = 12'hF0F;

  logic                   Clk;
  logic                   Reset;
  logic                   pix_en;
  logic [9:0]             hCount;
  logic [9:0]             vCount;
  logic                   bright;
  logic [ROWS*COLS-1:0]   board_occ;
  logic [3*ROWS*COLS-1:0] board_color;
  logic [ROWS-1:0]        flash_rows;
  logic                   border_en;
  logic [11:0]            rgb;
  logic                   frame_tick;

  int n_chk;
  int n_pass;
  int ticks;
  int fc;
  logic [7:0] fc8;
  logic [11:0] exp_flash;

  tetris_board_renderer #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .X0(X0), .Y0(Y0),
    .V_ACTIVE(VA), .FLASH_BIT(3)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_en      (pix_en),
    .hCount      (hCount),
    .vCount      (vCount),
    .bright      (bright),
    .board_occ   (board_occ),
    .board_color (board_color),
    .flash_rows  (flash_rows),
    .border_en   (border_en),
    .rgb         (rgb),
    .frame_tick  (frame_tick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) if (frame_tick) ticks <= ticks + 1;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic strobe(input int h, input int v);
    hCount = 10'(h);
    vCount = 10'(v);
    pix_en = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  // Replays lines from Y0 down to y, then scans pixels up to x; rgb shows x one strobe later.
  task automatic check_px(input string tag, input int x, input int y, input logic [11:0] exp);
    for (int l = Y0; l <= y; l++) strobe(0, l);
    for (int h = X0 - 2; h <= x + 1; h++) strobe(h, y);
    chk(tag, rgb, exp);
  endtask

  task automatic snap();
    strobe(0, VA);
    chk("tick_hi", 12'(frame_tick), 12'h001);
    strobe(1, VA);
    chk("tick_lo", 12'(frame_tick), 12'h000);
    fc++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; ticks = 0; fc = 0;
    Reset = 1'b1; pix_en = 1'b0; hCount = '0; vCount = '0; bright = 1'b1;
    board_occ = '0; board_color = '0; flash_rows = '0; border_en = 1'b0;

    // Reset held for 3 strobes inside the board
    for (int i = 0; i < 3; i++) begin
      strobe(X0 + 5 + i, Y0 + 5);
      chk("rst_rgb", rgb, C_BLACK);
    end
    chk("rst_tick", 12'(frame_tick), 12'h000);
    Reset = 1'b0;
    check_px("rst_well", X0 + 5, Y0 + 5, C_GREY);

    // Single cell, colour 3, no bevel
    board_occ[0] = 1'b1;
    board_color[2:0] = 3'd3;
    snap();
    check_px("c0_origin",  X0, Y0, C_PAL3);
    check_px("c1_grey",    X0 + CELL, Y0, C_GREY);
    check_px("c0_corner",  X0 + CELL - 1, Y0 + CELL - 1, C_PAL3);
    check_px("row1_grey",  X0, Y0 + CELL, C_GREY);
    check_px("frame_left", X0 - 1, Y0, C_GREY);
    check_px("outside",    X0 - 2, Y0, C_BLACK);
    check_px("last_col",   X0 + COLS*CELL - 1, Y0 + 5, C_GREY);
    check_px("frame_rt",   X0 + COLS*CELL, Y0 + 5, C_GREY);

    // Bevel on top/left edge
    border_en = 1'b1;
    check_px("bevel_tl",   X0, Y0, C_DIM3);
    check_px("bevel_top",  X0 + 1, Y0, C_DIM3);
    check_px("bevel_in",   X0 + 1, Y0 + 1, C_PAL3);
    border_en = 1'b0;

    // Live board changes mid-frame must not show until the next snapshot
    board_occ = '0;
    board_occ[0] = 1'b1;
    board_occ[1*COLS + 2] = 1'b1;
    board_color = '0;
    board_color[2:0] = 3'd5;
    strobe(0, 100);
    check_px("no_tear", X0 + 1, Y0 + 1, C_PAL3);
    ticks = 0;
    strobe(5, VA);
    strobe(6, VA);
    chk("no_snap_h", 12'(ticks), 12'd0);
    snap();
    strobe(7, VA);
    chk("one_tick", 12'(ticks), 12'd1);
    check_px("new_c0",   X0 + 1, Y0 + 1, C_PAL5);
    check_px("pal0_lg",  X0 + 2*CELL + 1, Y0 + CELL + 1, C_LG);

    // Row 0 flashes on frame_cnt bit 3; row 1 stays steady
    flash_rows[0] = 1'b1;
    for (int f = 0; f < 17; f++) begin
      snap();
      fc8 = 8'(fc);
      exp_flash = fc8[3] ? C_GREY : C_PAL5;
      check_px("flash_r0", X0 + 1, Y0 + 1, exp_flash);
      check_px("steady_r1", X0 + 2*CELL + 1, Y0 + CELL + 1, C_LG);
    end

    // Blanking qualifier and hold while pix_en is low
    bright = 1'b0;
    check_px("dark", X0 + 1, Y0 + 1, C_BLACK);
    pix_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hCount = 10'(X0 + 50 + i);
      @(posedge Clk); #1;
      chk("hold_dark", rgb, C_BLACK);
    end
    bright = 1'b1;
    fc8 = 8'(fc);
    exp_flash = fc8[3] ? C_GREY : C_PAL5;
    check_px("lit", X0 + 1, Y0 + 1, exp_flash);
    pix_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hCount = 10'(X0 - 10 + i);
      vCount = 10'(VA);
      @(posedge Clk); #1;
      chk("hold_lit", rgb, exp_flash);
    end
    chk("hold_no_tick", 12'(frame_tick), 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
